ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage of the 5-stage MIPS32 pipeline. It owns the HI/LO registers and executes MULT, MULTU, DIV and DIVU over multiple cycles. While an operation is in flight, it raises a stall request that the pipeline hazard logic turns into PC/IF_ID enable-low and ID control NOP. It is the stall initiator feeding the hazard/forwarding control path.

Parameters:
WIDTH, 32, operand width and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  EX-stage instruction is MULT/MULTU/DIV/DIVU; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
rs_data  input  WIDTH  forwarded Rs operand (multiplicand / dividend)
rt_data  input  WIDTH  forwarded Rt operand (multiplier / divisor)
hilo_read  input  1  ID-stage instruction is MFHI/MFLO
mthi  input  1  EX-stage MTHI, writes rs_data to HI
mtlo  input  1  EX-stage MTLO, writes rs_data to LO
hi_out  output  WIDTH  HI register
lo_out  output  WIDTH  LO register
busy  output  1  operation in flight
done  output  1  one-cycle pulse when HI/LO are updated by an operation
stall_req  output  1  to hazard unit; freezes PC and IF_ID and injects an ID NOP

Behaviour:
- Reset: state IDLE; hi_out=0, lo_out=0, busy=0, done=0, stall_req=0; internal accumulators cleared. Reset mid-operation aborts the operation, and HI/LO become 0.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + start (cycle N):
  - Latch operand magnitudes. For signed ops, take the two's-complement absolute value and record the result signs: quotient/product negative if the operand signs differ; remainder takes the dividend sign.
  - Load counter = WIDTH.
  - Go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL:
  - Each cycle is one shift-add step on a 2*WIDTH accumulator: if the multiplier LSB is 1, add the multiplicand to the upper half; then shift right 1.
  - Decrement the counter; at counter==1, go to FIX.
- DIV:
  - Each cycle is one restoring step: shift {rem,quo} left 1; trial-subtract the divisor from rem; if the result is non-negative, keep it and set quo LSB.
  - Decrement the counter; at counter==1, go to FIX.
- FIX (cycle N+WIDTH+1):
  - Apply sign correction; write HI/LO; pulse done; return to IDLE.
  - MUL results: HI=upper word, LO=lower word.
  - DIV results: LO=quotient, HI=remainder.
- Latency: start at cycle N gives busy=1 in cycles N+1..N+WIDTH+1, and HI/LO are valid from cycle N+WIDTH+2 (34 cycles at WIDTH=32). busy=0 in IDLE.
- stall_req = busy & (hilo_read | start | mthi | mtlo).
  - An independent instruction proceeds without stalling.
  - In the cycle FIX completes, stall_req is still 1 if requested. The dependent instruction sees the new HI/LO one cycle later.
- start, mthi and mtlo while busy are ignored; the stall holds the instruction until IDLE.
- MTHI/MTLO in IDLE: write rs_data at the clock edge, no done pulse. If start and mthi/mtlo coincide, start wins and the write is dropped.
- Divide by zero: no trap, fixed iteration count. Raw unsigned result is LO=all-ones, HI=dividend magnitude; signed sign correction is then applied as normal.
- Signed overflow case (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- Products use full 2*WIDTH precision with no overflow flag. MULT of 0x80000000 by 0x80000000 gives HI=0x40000000, LO=0.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, start at cycle 0 -> busy cycles 1..33; done at cycle 33; HI=0xFFFFFFFE, LO=0x00000001 from cycle 34.
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU rs=100, rt=0 -> LO=0xFFFFFFFF, HI=100.
- DIVU 100/7 started, hilo_read=1 from cycle 2 -> stall_req=1 cycles 2..33 and 0 at cycle 34 with LO=14, HI=2. Unrelated instructions (hilo_read=0) give stall_req=0 throughout.
- MTLO rs=0x1234 in IDLE -> lo_out=0x1234 next cycle, done=0. MTHI asserted while busy -> stall_req=1 and HI unchanged until the op finishes.
- reset asserted at cycle 10 of a MULT -> next cycle: state IDLE, busy=0, HI=LO=0, no done pulse. A following start executes normally.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle of the EX-stage multiply/divide unit: instruction
// decode, forwarded operands, HI/LO read-back and hazard status.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hilo_read;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             stall_req;

  modport master (
    output start, op, rs_data, rt_data, hilo_read, mthi, mtlo,
    input  hi_out, lo_out, busy, done, stall_req
  );

  modport slave (
    input  start, op, rs_data, rt_data, hilo_read, mthi, mtlo,
    output hi_out, lo_out, busy, done, stall_req
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; one shift-add or
// restoring-divide step per cycle, sign fix-up in a final cycle.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  ex_muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v,
                                              input logic          is_neg);
    return is_neg ? neg_w(v) : v;
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] acc_hi_r;   // product upper half, or partial remainder
  logic [WIDTH-1:0] acc_lo_r;   // multiplier bits, or dividend/quotient bits
  logic [WIDTH-1:0] opb_r;      // multiplicand or divisor magnitude
  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;

  logic             rs_neg_s;
  logic             rt_neg_s;
  logic [WIDTH-1:0] rs_mag_s;
  logic [WIDTH-1:0] rt_mag_s;
  logic [WIDTH-1:0] mul_add_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_sh_s;
  logic [WIDTH-1:0] div_diff_s;
  logic             div_ok_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] fix_hi_s;
  logic [WIDTH-1:0] fix_lo_s;

  // Operand magnitudes, per-step datapath and final sign correction.
  always_comb begin
    rs_neg_s   = bus.op[0] & bus.rs_data[WIDTH-1];
    rt_neg_s   = bus.op[0] & bus.rt_data[WIDTH-1];
    rs_mag_s   = abs_w(bus.rs_data, rs_neg_s);
    rt_mag_s   = abs_w(bus.rt_data, rt_neg_s);

    mul_add_s  = acc_lo_r[0] ? opb_r : {WIDTH{1'b0}};
    mul_sum_s  = {1'b0, acc_hi_r} + {1'b0, mul_add_s};

    // The shifted remainder can be WIDTH+1 bits; the difference fits in WIDTH
    // whenever it is kept.
    div_sh_s   = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_ok_s   = (div_sh_s >= {1'b0, opb_r});
    div_diff_s = div_sh_s[WIDTH-1:0] - opb_r;

    prod_s     = {acc_hi_r, acc_lo_r};
    fix_hi_s   = {WIDTH{1'b0}};
    fix_lo_s   = {WIDTH{1'b0}};
    if (is_div_r) begin
      fix_lo_s = neg_q_r ? neg_w(acc_lo_r) : acc_lo_r;
      fix_hi_s = neg_r_r ? neg_w(acc_hi_r) : acc_hi_r;
    end else begin
      prod_s   = neg_q_r ? neg_d({acc_hi_r, acc_lo_r}) : {acc_hi_r, acc_lo_r};
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM, iteration datapath and HI/LO ownership.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= {WIDTH{1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            cnt_r    <= CW'(WIDTH);
            acc_hi_r <= {WIDTH{1'b0}};
            is_div_r <= bus.op[1];
            neg_q_r  <= rs_neg_s ^ rt_neg_s;
            neg_r_r  <= rs_neg_s;
            busy_r   <= 1'b1;
            if (bus.op[1]) begin
              acc_lo_r <= rs_mag_s;
              opb_r    <= rt_mag_s;
              state_r  <= DIV;
            end else begin
              acc_lo_r <= rt_mag_s;
              opb_r    <= rs_mag_s;
              state_r  <= MUL;
            end
          end else begin
            if (bus.mthi) begin
              hi_r <= bus.rs_data;
            end else begin
              hi_r <= hi_r;
            end
            if (bus.mtlo) begin
              lo_r <= bus.rs_data;
            end else begin
              lo_r <= lo_r;
            end
          end
        end
        MUL: begin
          acc_hi_r <= mul_sum_s[WIDTH:1];
          acc_lo_r <= {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
          cnt_r    <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= FIX;
            done_r  <= 1'b1;
          end else begin
            state_r <= MUL;
          end
        end
        DIV: begin
          acc_hi_r <= div_ok_s ? div_diff_s : div_sh_s[WIDTH-1:0];
          acc_lo_r <= {acc_lo_r[WIDTH-2:0], div_ok_s};
          cnt_r    <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= FIX;
            done_r  <= 1'b1;
          end else begin
            state_r <= DIV;
          end
        end
        FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi_out    = hi_r;
  assign bus.lo_out    = lo_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  // Only instructions that touch HI/LO or the unit itself must wait.
  assign bus.stall_req = busy_r & (bus.hilo_read | bus.start | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed MULT/DIV vectors, hazard
// stall timing, MTHI/MTLO and mid-operation reset.
module tb_ex_muldiv_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  logic        done_seen;

  ex_muldiv_unit_if #(.WIDTH(32)) bus();

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: HI/LO are compared the cycle after each done pulse.
  always @(negedge clk) begin
    if (done_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done with empty queue at %0t", $time);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hi", bus.hi_out, e[63:32]);
        check("result_lo", bus.lo_out, e[31:0]);
      end
    end
    done_seen <= bus.done;
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int hr_from, input bit do_mthi);
    bit exp_stall;
    exp_q.push_back({ehi, elo});
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.rs_data   = 32'hDEAD_BEEF;
      bus.hilo_read = (hr_from != 0) && (k >= hr_from);
      bus.mthi      = do_mthi && (k >= 5) && (k <= 8);
      exp_stall     = (k <= 33) && (((hr_from != 0) && (k >= hr_from)) ||
                                    (do_mthi && (k >= 5) && (k <= 8)));
      #1;
      check("busy", {31'd0, bus.busy}, {31'd0, k <= 33});
      check("done", {31'd0, bus.done}, {31'd0, k == 33});
      check("stall_req", {31'd0, bus.stall_req}, {31'd0, exp_stall});
      if (k <= 33) begin
        check("hi_hold", bus.hi_out, model_hi);
        check("lo_hold", bus.lo_out, model_lo);
      end
    end
    bus.hilo_read = 1'b0;
    bus.mthi      = 1'b0;
    model_hi = ehi;
    model_lo = elo;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    checks = 0;
    errors = 0;
    done_seen = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    bus.hilo_read = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b10, 32'd100,       32'd0,         32'd100,      32'hFFFF_FFFF};
    vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6] = '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'h0000_0001};
    vecs[7] = '{2'b00, 32'h1234_5678, 32'd0,         32'd0,         32'd0};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_hi", bus.hi_out, 32'd0);
    check("rst_lo", bus.lo_out, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_stall", {31'd0, bus.stall_req}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].ehi, vecs[i].elo, 0, 1'b0);
    end

    // Dependent MFHI/MFLO held from cycle 2 until the result lands.
    run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 2, 1'b0);
    // MTHI while busy is stalled and must not disturb HI.
    run_op(2'b10, 32'h0000_1000, 32'h0000_0010, 32'd0, 32'h0000_0100, 0, 1'b1);

    @(posedge clk); #1;
    bus.mtlo = 1'b1;
    bus.rs_data = 32'h0000_1234;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    #1;
    check("mtlo_lo", bus.lo_out, 32'h0000_1234);
    check("mtlo_hi", bus.hi_out, model_hi);
    check("mtlo_done", {31'd0, bus.done}, 32'd0);
    model_lo = 32'h0000_1234;

    // Abort a MULT with reset at cycle 10.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.rs_data = 32'd5;
    bus.rt_data = 32'd9;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      #1;
      check("abort_busy", {31'd0, bus.busy}, 32'd1);
    end
    reset = 1'b1;
    bus.hilo_read = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_busy_clr", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_hi", bus.hi_out, 32'd0);
    check("abort_lo", bus.lo_out, 32'd0);
    check("abort_stall", {31'd0, bus.stall_req}, 32'd0);
    bus.hilo_read = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    repeat (2) @(posedge clk);

    run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
